nes_controller_poller: RTL

//  Sequences the NES pad serial link from the single system clock: periodically pulses nes_latch,

---
 rtl/nes_pkg.sv | 29 ++
 rtl/nes_controller_poller_tick_gen.sv | 32 +++
 rtl/nes_controller_poller.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/nes_pkg.sv
// Shared types and constants for the NES pad poller.
package nes_pkg;

    // Frame sequencer states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LATCH = 3'd1,
        LOW   = 3'd2,
        HIGH  = 3'd3,
        DONE  = 3'd4
    } nes_state_t;

    // Bit positions in the published button vector (pad shift order)
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    localparam int NES_BITS = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/nes_controller_poller_tick_gen.sv
// Periodic one-cycle tick: counts 0..PERIOD-1 while enabled, held at 0 otherwise.
module tick_gen #(
    parameter int PERIOD = 66666
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_tick
);

    localparam int                CNT_W = $clog2(PERIOD + 1);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0]  ONE   = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == LAST);
    assign o_tick = i_en && w_last;

    // Free-running period counter, wraps on terminal count
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (!i_en || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + ONE;
        end
    end

endmodule

// File: rtl/nes_controller_poller.sv
// NES pad poller: latch pulse, 8 shift clocks, synchronized sampling,
// button vector with valid/changed strobes. Single clock domain.
//
//  state | meaning
//  IDLE  | waiting for poll tick or force_poll
//  LATCH | nes_latch high for LATCH_CYCLES
//  LOW   | nes_clock low half-period; bit sampled on last cycle
//  HIGH  | nes_clock high half-period; advance bit or finish
//  DONE  | one cycle: buttons/valid/changed published
module nes_controller_poller
    import nes_pkg::*;
#(
    parameter int CLK_FREQ     = 50000000,
    parameter int POLL_FREQ    = 750,
    parameter int LATCH_CYCLES = 600,
    parameter int HALF_CYCLES  = 300
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_poll_en,
    input  logic                i_force_poll,
    input  logic                i_nes_data,
    output logic                o_nes_latch,
    output logic                o_nes_clock,
    output logic [NES_BITS-1:0] o_buttons,
    output logic                o_valid,
    output logic                o_changed,
    output logic                o_busy
);

    localparam int               POLL_CYCLES = CLK_FREQ / POLL_FREQ;
    localparam int               PH_W        = $clog2(max_int(LATCH_CYCLES, HALF_CYCLES) + 1);
    localparam logic [PH_W-1:0]  LATCH_LOAD  = PH_W'(LATCH_CYCLES - 1);
    localparam logic [PH_W-1:0]  HALF_LOAD   = PH_W'(HALF_CYCLES - 1);
    localparam logic [PH_W-1:0]  PH_ONE      = PH_W'(1);
    localparam logic [2:0]       LAST_BIT    = 3'(NES_BITS - 1);

    // A frame must finish well before the next poll tick, otherwise ticks are silently lost
    if (LATCH_CYCLES + 2 * NES_BITS * HALF_CYCLES >= POLL_CYCLES) begin : g_bad_timing
        $error("nes_controller_poller: frame length does not fit in poll period");
    end

    nes_state_t          r_state;
    nes_state_t          w_next_state;
    logic [PH_W-1:0]     r_phase;
    logic [PH_W-1:0]     w_phase_next;
    logic                w_phase_done;
    logic [2:0]          r_bit_idx;
    logic                r_sync1;
    logic                r_sync2;
    logic [NES_BITS-1:0] r_shreg;
    logic [NES_BITS-1:0] r_buttons;
    logic                r_latch;
    logic                r_clock;
    logic                r_valid;
    logic                r_changed;
    logic                r_busy;
    logic                w_tick;
    logic                w_start;

    tick_gen #(
        .PERIOD (POLL_CYCLES)
    ) u_tick_gen (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (i_poll_en),
        .o_tick (w_tick)
    );

    assign w_start      = w_tick || i_force_poll;
    assign w_phase_done = (r_phase == '0);

    // Two-flop synchronizer; reset to 1 so an unplugged/idle line reads as released
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_nes_data;
            r_sync2 <= r_sync1;
        end
    end

    // Next-state decode and phase counter reload on every state change
    always_comb begin
        w_next_state = r_state;
        w_phase_next = w_phase_done ? '0 : (r_phase - PH_ONE);
        unique case (r_state)
            IDLE:  if (w_start)      w_next_state = LATCH;
            LATCH: if (w_phase_done) w_next_state = LOW;
            LOW:   if (w_phase_done) w_next_state = HIGH;
            HIGH:  if (w_phase_done) w_next_state = (r_bit_idx == LAST_BIT) ? DONE : LOW;
            DONE:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
        if (w_next_state != r_state) begin
            unique case (w_next_state)
                LATCH:     w_phase_next = LATCH_LOAD;
                LOW, HIGH: w_phase_next = HALF_LOAD;
                default:   w_phase_next = '0;
            endcase
        end
    end

    // State and phase registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_phase <= '0;
        end else begin
            r_state <= w_next_state;
            r_phase <= w_phase_next;
        end
    end

    // Bit index and shift register; pad data is active-low
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bit_idx <= '0;
            r_shreg   <= '0;
        end else begin
            if (r_state == LATCH) begin
                r_bit_idx <= '0;
            end else if (r_state == HIGH && w_phase_done && r_bit_idx != LAST_BIT) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            if (r_state == LOW && w_phase_done) begin
                r_shreg[r_bit_idx] <= ~r_sync2;
            end
        end
    end

    // Registered outputs, decoded from the state being entered
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_latch   <= 1'b0;
            r_clock   <= 1'b0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_changed <= 1'b0;
            r_buttons <= '0;
        end else begin
            r_latch   <= (w_next_state == LATCH);
            r_clock   <= (w_next_state == HIGH);
            r_busy    <= (w_next_state != IDLE);
            r_valid   <= (w_next_state == DONE);
            r_changed <= (w_next_state == DONE) && (r_shreg != r_buttons);
            if (w_next_state == DONE) begin
                r_buttons <= r_shreg;
            end
        end
    end

    assign o_nes_latch = r_latch;
    assign o_nes_clock = r_clock;
    assign o_busy      = r_busy;
    assign o_valid     = r_valid;
    assign o_changed   = r_changed;
    assign o_buttons   = r_buttons;

endmodule
